// File: rtl/htif_mailbox_pkg.sv
// Shared types and register map for the HTIF tohost/fromhost mailbox.
package htif_mailbox_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPending  = 3'd1,
        StWaitResp = 3'd2,
        StExited   = 3'd3
    } state_e;

    localparam logic [4:0] TohostOff   = 5'h00;
    localparam logic [4:0] FromhostOff = 5'h08;
    localparam logic [4:0] StatusOff   = 5'h10;
    localparam int unsigned RegSpan    = 24;

    localparam int unsigned StatusStateLsb = 0;
    localparam int unsigned StatusEocBit   = 3;

endpackage

// File: rtl/htif_mailbox_if.sv
// Register-interface request/response bundle; response is combinational with accept.
interface htif_mailbox_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64
) ();
    logic                   req_valid;
    logic                   req_ready;
    logic [AddrWidth-1:0]   req_addr;
    logic                   req_write;
    logic [DataWidth-1:0]   req_wdata;
    logic [DataWidth/8-1:0] req_wstrb;
    logic [DataWidth-1:0]   rsp_rdata;
    logic                   rsp_error;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, req_wstrb,
        input  req_ready, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, req_wstrb,
        output req_ready, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/htif_mailbox_regs.sv
// Address decode, strobe/error checking and lo/hi write shadow for the mailbox registers.
module htif_mailbox_regs
    import htif_mailbox_pkg::*;
#(
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          DataWidth = 64,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    htif_mailbox_if.slave bus,
    input  state_e        state_i,
    input  logic          eoc_i,
    input  logic [63:0]   tohost_i,
    input  logic [63:0]   fromhost_i,
    output logic          tohost_commit_o,
    output logic [63:0]   tohost_wdata_o,
    output logic          fromhost_clear_o
);
    localparam bit Narrow = (DataWidth == 32);

    logic [AddrWidth-1:0] offset;
    logic                 in_range, sel_tohost, sel_fromhost, sel_status, final_word;
    logic                 busy, err, stall, accept_wr;
    logic [63:0]          wdata_ext, status, rdata_full;
    logic [31:0]          shadow_q;

    assign offset       = bus.req_addr - BaseAddr;
    assign in_range     = (bus.req_addr >= BaseAddr) && (offset < AddrWidth'(RegSpan));
    assign sel_tohost   = in_range && (offset[4:3] == TohostOff[4:3]);
    assign sel_fromhost = in_range && (offset[4:3] == FromhostOff[4:3]);
    assign sel_status   = in_range && (offset[4:3] == StatusOff[4:3]);
    // On a 32-bit bus only the hi half completes a 64-bit register write.
    assign final_word   = !Narrow || offset[2];
    assign busy         = (state_i == StPending) || (state_i == StWaitResp);

    always_comb begin
        err = 1'b0;
        if (!in_range) begin
            err = 1'b1;
        end else if (bus.req_write) begin
            if (sel_status || !(&bus.req_wstrb)) begin
                err = 1'b1;
            end else if (sel_fromhost && (bus.req_wdata != '0)) begin
                err = 1'b1;
            end
        end
    end

    assign stall     = bus.req_valid && bus.req_write && sel_tohost && final_word && busy && !err;
    assign accept_wr = bus.req_valid && bus.req_write && !err && !stall;

    assign bus.req_ready = !stall;
    assign bus.rsp_error = bus.req_valid && err;

    assign wdata_ext      = 64'(bus.req_wdata);
    assign tohost_wdata_o = Narrow ? {wdata_ext[31:0], shadow_q} : wdata_ext;
    assign tohost_commit_o  = accept_wr && sel_tohost && final_word;
    // A zero write to either FROMHOST half acknowledges the whole register.
    assign fromhost_clear_o = accept_wr && sel_fromhost;

    always_comb begin
        status = '0;
        status[StatusStateLsb +: 3] = state_i;
        status[StatusEocBit] = eoc_i;
    end

    always_comb begin
        rdata_full = '0;
        if (sel_tohost) begin
            rdata_full = tohost_i;
        end else if (sel_fromhost) begin
            rdata_full = fromhost_i;
        end else if (sel_status) begin
            rdata_full = status;
        end
    end

    assign bus.rsp_rdata = DataWidth'((Narrow && offset[2]) ? (rdata_full >> 32) : rdata_full);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
        end else if (Narrow && accept_wr && sel_tohost && !final_word) begin
            shadow_q <= wdata_ext[31:0];
        end
    end

endmodule

// File: rtl/htif_mailbox.sv
// Target-side HTIF tohost/fromhost mailbox: exit/syscall posting and host handshake FSM.
module htif_mailbox
    import htif_mailbox_pkg::*;
#(
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          DataWidth = 64,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    htif_mailbox_if.slave bus,
    output logic          tohost_valid_o,
    input  logic          tohost_ready_i,
    output logic [63:0]   tohost_data_o,
    input  logic          fromhost_valid_i,
    output logic          fromhost_ready_o,
    input  logic [63:0]   fromhost_data_i,
    output logic          eoc_o,
    output logic [31:0]   exit_code_o
);
    state_e      state_q;
    logic [63:0] tohost_q, fromhost_q, tohost_wdata;
    logic        tohost_commit, fromhost_clear;
    logic        tohost_valid_q, fromhost_ready_q, eoc_q;
    logic [31:0] exit_code_q;

    htif_mailbox_regs #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth),
        .BaseAddr  (BaseAddr)
    ) u_regs (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .bus              (bus),
        .state_i          (state_q),
        .eoc_i            (eoc_q),
        .tohost_i         (tohost_q),
        .fromhost_i       (fromhost_q),
        .tohost_commit_o  (tohost_commit),
        .tohost_wdata_o   (tohost_wdata),
        .fromhost_clear_o (fromhost_clear)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= StIdle;
            tohost_q         <= '0;
            fromhost_q       <= '0;
            tohost_valid_q   <= 1'b0;
            fromhost_ready_q <= 1'b0;
            eoc_q            <= 1'b0;
            exit_code_q      <= '0;
        end else begin
            if (fromhost_clear) begin
                fromhost_q <= '0;
            end
            case (state_q)
                StIdle: begin
                    if (tohost_commit && (tohost_wdata != '0)) begin
                        tohost_q <= tohost_wdata;
                        if (tohost_wdata[0]) begin
                            state_q     <= StExited;
                            eoc_q       <= 1'b1;
                            exit_code_q <= tohost_wdata[32:1];
                        end else begin
                            state_q        <= StPending;
                            tohost_valid_q <= 1'b1;
                        end
                    end
                end
                StPending: begin
                    if (tohost_ready_i) begin
                        state_q          <= StWaitResp;
                        tohost_valid_q   <= 1'b0;
                        fromhost_ready_q <= fromhost_clear || (fromhost_q == '0);
                    end
                end
                StWaitResp: begin
                    // Host data is assigned last so it wins over a same-cycle core clear.
                    if (fromhost_valid_i && fromhost_ready_q) begin
                        fromhost_q       <= fromhost_data_i;
                        tohost_q         <= '0;
                        state_q          <= StIdle;
                        fromhost_ready_q <= 1'b0;
                    end else begin
                        fromhost_ready_q <= fromhost_clear || (fromhost_q == '0);
                    end
                end
                StExited: ;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tohost_valid_o   = tohost_valid_q;
    assign tohost_data_o    = tohost_q;
    assign fromhost_ready_o = fromhost_ready_q;
    assign eoc_o            = eoc_q;
    assign exit_code_o      = exit_code_q;

endmodule

// File: tb/tb_htif_mailbox.sv
// Directed bench for htif_mailbox on a 64-bit and a 32-bit register bus.
module tb_htif_mailbox;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    htif_mailbox_if #(.AddrWidth(32), .DataWidth(64)) b64 ();
    htif_mailbox_if #(.AddrWidth(32), .DataWidth(32)) b32 ();

    logic        th_valid64, th_ready64, fh_valid64, fh_ready64, eoc64;
    logic [63:0] th_data64, fh_data64;
    logic [31:0] code64;
    logic        th_valid32, th_ready32, fh_valid32, fh_ready32, eoc32;
    logic [63:0] th_data32, fh_data32;
    logic [31:0] code32;

    htif_mailbox #(.AddrWidth(32), .DataWidth(64), .BaseAddr(32'h0)) dut64 (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .bus              (b64),
        .tohost_valid_o   (th_valid64),
        .tohost_ready_i   (th_ready64),
        .tohost_data_o    (th_data64),
        .fromhost_valid_i (fh_valid64),
        .fromhost_ready_o (fh_ready64),
        .fromhost_data_i  (fh_data64),
        .eoc_o            (eoc64),
        .exit_code_o      (code64)
    );

    htif_mailbox #(.AddrWidth(32), .DataWidth(32), .BaseAddr(32'h0)) dut32 (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .bus              (b32),
        .tohost_valid_o   (th_valid32),
        .tohost_ready_i   (th_ready32),
        .tohost_data_o    (th_data32),
        .fromhost_valid_i (fh_valid32),
        .fromhost_ready_o (fh_ready32),
        .fromhost_data_i  (fh_data32),
        .eoc_o            (eoc32),
        .exit_code_o      (code32)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] r_rdata;
    logic        r_err;
    int          r_wait;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic acc64(input logic wr, input logic [31:0] addr, input logic [63:0] wd,
                         input logic [7:0] strb);
        @(negedge clk);
        b64.req_valid = 1'b1;
        b64.req_write = wr;
        b64.req_addr  = addr;
        b64.req_wdata = wd;
        b64.req_wstrb = strb;
        r_wait = 0;
        #1;
        while (!b64.req_ready && r_wait < 50) begin
            @(negedge clk);
            #1;
            r_wait++;
        end
        r_rdata = b64.rsp_rdata;
        r_err   = b64.rsp_error;
        @(posedge clk);
        #1;
        b64.req_valid = 1'b0;
        b64.req_write = 1'b0;
    endtask

    task automatic acc32(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        b32.req_valid = 1'b1;
        b32.req_write = wr;
        b32.req_addr  = addr;
        b32.req_wdata = wd;
        b32.req_wstrb = 4'hF;
        r_wait = 0;
        #1;
        while (!b32.req_ready && r_wait < 50) begin
            @(negedge clk);
            #1;
            r_wait++;
        end
        r_rdata = 64'(b32.rsp_rdata);
        r_err   = b32.rsp_error;
        @(posedge clk);
        #1;
        b32.req_valid = 1'b0;
        b32.req_write = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic th_pulse64();
        @(negedge clk);
        th_ready64 = 1'b1;
        @(negedge clk);
        th_ready64 = 1'b0;
    endtask

    task automatic fh_send64(input logic [63:0] d);
        int n = 0;
        @(negedge clk);
        while (!fh_ready64 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fh_ready_before_send", 64'(fh_ready64), 64'd1);
        fh_valid64 = 1'b1;
        fh_data64  = d;
        @(negedge clk);
        fh_valid64 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        b64.req_valid = 1'b0; b64.req_write = 1'b0; b64.req_addr = '0;
        b64.req_wdata = '0;   b64.req_wstrb = '0;
        b32.req_valid = 1'b0; b32.req_write = 1'b0; b32.req_addr = '0;
        b32.req_wdata = '0;   b32.req_wstrb = '0;
        th_ready64 = 1'b0; fh_valid64 = 1'b0; fh_data64 = '0;
        th_ready32 = 1'b0; fh_valid32 = 1'b0; fh_data32 = '0;
        do_reset();

        // Reset state
        check("rst_eoc", 64'(eoc64), 64'd0);
        check("rst_code", 64'(code64), 64'd0);
        check("rst_th_valid", 64'(th_valid64), 64'd0);
        check("rst_fh_ready", 64'(fh_ready64), 64'd0);
        check("rst_th_data", th_data64, 64'd0);
        acc64(1'b0, 32'h10, '0, 8'h00);
        check("rst_status", r_rdata, 64'h0);

        // Zero commit ignored, then exit code 0
        acc64(1'b1, 32'h0, 64'h0, 8'hFF);
        acc64(1'b0, 32'h10, '0, 8'h00);
        check("zero_write_status", r_rdata, 64'h0);
        acc64(1'b1, 32'h0, 64'h1, 8'hFF);
        check("exit1_eoc", 64'(eoc64), 64'd1);
        check("exit1_code", 64'(code64), 64'd0);
        acc64(1'b0, 32'h10, '0, 8'h00);
        check("exit1_status", r_rdata, 64'hB);
        do_reset();
        check("rerst_eoc", 64'(eoc64), 64'd0);

        // Error responses in IDLE
        acc64(1'b0, 32'h20, '0, 8'h00);
        check("err_addr20", 64'(r_err), 64'd1);
        acc64(1'b0, 32'h18, '0, 8'h00);
        check("err_addr18", 64'(r_err), 64'd1);
        acc64(1'b1, 32'h10, 64'h3, 8'hFF);
        check("err_status_wr", 64'(r_err), 64'd1);
        acc64(1'b1, 32'h0, 64'h1, 8'h0F);
        check("err_partial_strb", 64'(r_err), 64'd1);
        check("err_no_eoc", 64'(eoc64), 64'd0);
        acc64(1'b1, 32'h8, 64'h5, 8'hFF);
        check("err_fromhost_nz", 64'(r_err), 64'd1);
        acc64(1'b0, 32'h10, '0, 8'h00);
        check("err_status_idle", r_rdata, 64'h0);
        check("ok_status_rd", 64'(r_err), 64'd0);

        // Syscall posted, held until host takes it
        acc64(1'b1, 32'h0, 64'h8000_1000, 8'hFF);
        check("sys_wr_err", 64'(r_err), 64'd0);
        check("sys_th_valid", 64'(th_valid64), 64'd1);
        check("sys_th_data", th_data64, 64'h8000_1000);
        repeat (3) @(negedge clk);
        check("sys_hold_valid", 64'(th_valid64), 64'd1);
        check("sys_hold_data", th_data64, 64'h8000_1000);
        acc64(1'b0, 32'h10, '0, 8'h00);
        check("sys_status_pend", r_rdata, 64'h1);
        th_pulse64();
        check("sys_taken_valid", 64'(th_valid64), 64'd0);
        check("sys_fh_ready", 64'(fh_ready64), 64'd1);
        fh_send64(64'h1);
        acc64(1'b0, 32'h8, '0, 8'h00);
        check("sys_fromhost", r_rdata, 64'h1);
        acc64(1'b0, 32'h0, '0, 8'h00);
        check("sys_tohost_zero", r_rdata, 64'h0);
        acc64(1'b0, 32'h10, '0, 8'h00);
        check("sys_status_idle", r_rdata, 64'h0);
        acc64(1'b1, 32'h8, 64'h0, 8'hFF);
        check("fh_clear_err", 64'(r_err), 64'd0);
        acc64(1'b0, 32'h8, '0, 8'h00);
        check("fh_cleared", r_rdata, 64'h0);

        // Second TOHOST write stalls while a syscall is outstanding
        acc64(1'b1, 32'h0, 64'h2000, 8'hFF);
        fork
            acc64(1'b1, 32'h0, 64'h3000, 8'hFF);
            begin
                repeat (3) @(negedge clk);
                th_pulse64();
                fh_send64(64'h77);
            end
        join
        check("stall_seen", 64'(r_wait > 0 && r_wait < 50), 64'd1);
        check("stall_commit_data", th_data64, 64'h3000);
        check("stall_commit_valid", 64'(th_valid64), 64'd1);
        acc64(1'b0, 32'h8, '0, 8'h00);
        check("stall_fromhost", r_rdata, 64'h77);

        // fromhost_ready held off until the core acknowledges
        th_pulse64();
        check("fh_block", 64'(fh_ready64), 64'd0);
        acc64(1'b0, 32'h10, '0, 8'h00);
        check("wait_status", r_rdata, 64'h2);
        acc64(1'b1, 32'h8, 64'h0, 8'hFF);
        check("fh_unblock", 64'(fh_ready64), 64'd1);
        fork
            acc64(1'b1, 32'h8, 64'h0, 8'hFF);
            begin
                @(negedge clk);
                fh_valid64 = 1'b1;
                fh_data64  = 64'h99;
                @(negedge clk);
                fh_valid64 = 1'b0;
            end
        join
        check("race_clear_err", 64'(r_err), 64'd0);
        acc64(1'b0, 32'h8, '0, 8'h00);
        check("race_host_wins", r_rdata, 64'h99);

        // Exit 0x2B and terminal behaviour
        acc64(1'b1, 32'h0, 64'h2B, 8'hFF);
        check("exit_eoc", 64'(eoc64), 64'd1);
        check("exit_code", 64'(code64), 64'd21);
        acc64(1'b1, 32'h0, 64'h5, 8'hFF);
        check("exited_wr_err", 64'(r_err), 64'd0);
        check("exited_wr_nostall", 64'(r_wait), 64'd0);
        check("exited_code_held", 64'(code64), 64'd21);
        check("exited_eoc_held", 64'(eoc64), 64'd1);
        acc64(1'b0, 32'h10, '0, 8'h00);
        check("exited_status", r_rdata, 64'hB);

        // 32-bit bus: lo/hi split
        do_reset();
        acc32(1'b1, 32'h0, 32'h5);
        check("n32_lo_no_eoc", 64'(eoc32), 64'd0);
        acc32(1'b1, 32'h4, 32'h0);
        check("n32_eoc", 64'(eoc32), 64'd1);
        check("n32_code", 64'(code32), 64'd2);
        acc32(1'b0, 32'h10, 32'h0);
        check("n32_status", r_rdata, 64'hB);

        // 32-bit syscall, then reset while waiting for the host
        do_reset();
        acc32(1'b1, 32'h0, 32'h1000);
        acc32(1'b1, 32'h4, 32'h1);
        check("n32_th_valid", 64'(th_valid32), 64'd1);
        check("n32_th_data", th_data32, 64'h1_0000_1000);
        acc32(1'b0, 32'h4, 32'h0);
        check("n32_rd_hi", r_rdata, 64'h1);
        @(negedge clk);
        th_ready32 = 1'b1;
        @(negedge clk);
        th_ready32 = 1'b0;
        check("n32_fh_ready", 64'(fh_ready32), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_th_valid", 64'(th_valid32), 64'd0);
        check("arst_fh_ready", 64'(fh_ready32), 64'd0);
        check("arst_th_data", th_data32, 64'd0);
        check("arst_eoc", 64'(eoc32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_fh_ready", 64'(fh_ready32), 64'd0);
        acc32(1'b0, 32'h10, 32'h0);
        check("post_rst_status", r_rdata, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
